bcd_updown_display: RTL and testbench
=====================================

# bcd_updown_display

Parametrised N-digit up/down counter with integrated switch debouncing, press-and-hold auto-repeat, decimal or hex digit mode, and registered active-low seven-segment outputs for every digit. It sits between the raw board push-buttons and the seven-segment pins, replacing a fixed single-digit counter with a separate per-button debouncer. It is self-contained and has no handshake with other blocks.

## Interface
- NUM_DIGITS, 2, number of display digits (1..8)
- HEX_MODE, 0, 0: each digit counts 0-9 (BCD); 1: each digit counts 0-F
- DEBOUNCE_LIMIT, 250000, consecutive stable cycles required before a debounced level changes (>=2)
- REPEAT_DELAY, 12500000, hold cycles after the initial step before auto-repeat starts (>=1)
- REPEAT_PERIOD, 2500000, cycles between auto-repeat steps (>=1)

- i_Clk  in  1  system clock; all logic on posedge
- i_Rst_L  in  1  asynchronous, active-low reset
- i_Switch_Up  in  1  raw up button, active-high, asynchronous to i_Clk
- i_Switch_Down  in  1  raw down button, active-high, asynchronous to i_Clk
- o_Count  out  4*NUM_DIGITS  current value; digit k in bits [4k+3:4k], digit 0 is least significant
- o_Segments  out  7*NUM_DIGITS  active-low segments; digit k in bits [7k+6:7k], bit order A(lsb)..G(msb)
- o_Wrap  out  1  one-cycle pulse when a step wrapped the count

## Operation
- Each raw switch: 2-flop synchroniser, then debouncer: counter runs while synchronised level != debounced level, clears when they match; on reaching DEBOUNCE_LIMIT-1 the debounced level flips and the counter clears.
- Press event: debounced level 0->1 (registered previous level). Release produces no step.
- Per-direction repeat state machine: IDLE -> (press) DELAY, step issued on entry; DELAY -> REPEAT after REPEAT_DELAY cycles held, issuing a step; REPEAT issues a step every REPEAT_PERIOD cycles; any state -> IDLE when debounced level is 0.
- Auto-repeat runs only while exactly one debounced button is high; if both are high, both repeat timers hold and no repeat steps issue.
- Up and down steps in the same cycle cancel: no change, no o_Wrap.
- Up step: digit 0 increments; a digit at its max (9 or F) becomes 0 and carries to the next digit. All digits at max -> all zero, o_Wrap=1.
- Down step: digit 0 decrements; a digit at 0 becomes max and borrows. All zero -> all max, o_Wrap=1.
- In BCD mode digits never hold A-F. Segment decode covers 0-F (hex glyphs A,b,C,d,E,F).
- Reset mid-hold: all state clears; the held button must be debounced high again (fresh press) before stepping.

## Timing
- Reset values: o_Count=0, o_Segments = every digit 7'b1000000 (glyph "0"), o_Wrap=0, debounced levels 0, FSMs IDLE, all timers 0.
- Raw edge to debounced edge: 2 synchroniser cycles + DEBOUNCE_LIMIT cycles of stability.
- Step to o_Count: updated on the edge after the debounced press is seen (press detect registered, count updates next edge). o_Wrap asserted in the same cycle o_Count shows the wrapped value.
- o_Segments lags o_Count by exactly one cycle.
- Repeat: first repeat step REPEAT_DELAY cycles after the initial step, then every REPEAT_PERIOD cycles, exact.
- Debounce glitch shorter than DEBOUNCE_LIMIT cycles: no level change, no step.

## Test plan
- Params NUM_DIGITS=2, HEX_MODE=0, DEBOUNCE_LIMIT=4, REPEAT_DELAY=20, REPEAT_PERIOD=5. Reset -> o_Count=8'h00, o_Segments=14'h2040, o_Wrap=0; assert/deassert reset asynchronously mid-cycle -> outputs clear immediately.
- Up held 3 cycles then released (glitch) -> no change; up held 10 cycles -> o_Count=8'h01, o_Segments={7'b1000000,7'b1111001} one cycle later.
- From 8'h09 press up -> 8'h10; from 8'h99 press up -> 8'h00 with o_Wrap pulse; from 8'h00 press down -> 8'h99 with o_Wrap pulse.
- Up held 40 cycles past debounce -> steps at t0, t0+20, t0+25, t0+30, t0+35 (count 0->5); release -> no further steps.
- Both buttons pressed in the same cycle -> o_Count unchanged; down held while up held -> no repeats; release up -> down press required for further steps only after a new debounced press.
- HEX_MODE=1: from 8'h0F press up -> 8'h10, segments digit0 show "0"; from 8'hFF up -> 8'h00 with o_Wrap; 8'h0A displays glyph A (7'b0001000).

Source files
------------

// File: rtl/bcd_updown_display.sv
// Multi-digit up/down counter with seven-segment outputs.
// It includes switch debouncing and press-and-hold auto-repeat.
// Raw buttons are synchronised and then debounced.
// A repeat FSM for each direction issues step pulses.
// The digit chain applies those steps with carry or borrow.
// Count, wrap flag and segments are all driven from registers.
module bcd_updown_display #(
  parameter int NUM_DIGITS     = 2,
  parameter int HEX_MODE       = 0,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_PERIOD  = 2500000
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  input  logic                      i_Switch_Up,
  input  logic                      i_Switch_Down,
  output logic [4*NUM_DIGITS-1:0]   o_Count,
  output logic [7*NUM_DIGITS-1:0]   o_Segments,
  output logic                      o_Wrap
);

  localparam int DB_W    = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [3:0] DIGIT_MAX = (HEX_MODE != 0) ? 4'hF : 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  // Active-low glyphs, segment A in bit 0 through segment G in bit 6.
  function automatic logic [6:0] seg_decode(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic [1:0] raw_s;       // index 0 = up, 1 = down
  logic [1:0] deb_lvl_s;
  logic [1:0] step_s;
  logic       solo_s;      // exactly one debounced button held

  assign raw_s  = {i_Switch_Down, i_Switch_Up};
  assign solo_s = deb_lvl_s[0] ^ deb_lvl_s[1];

  for (genvar d = 0; d < 2; d++) begin : g_dir
    logic             meta_r;
    logic             sync_r;
    logic             deb_r;
    logic             deb_prev_r;
    logic [DB_W-1:0]  db_cnt_r;
    rpt_state_t       state_r;
    logic [RPT_W-1:0] tmr_r;
    logic             step_r;
    logic             press_s;

    assign press_s      = deb_r & ~deb_prev_r;
    assign deb_lvl_s[d] = deb_r;
    assign step_s[d]    = step_r;

    // Two-flop synchroniser for the asynchronous raw button
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        meta_r <= 1'b0;
        sync_r <= 1'b0;
      end else begin
        meta_r <= raw_s[d];
        sync_r <= meta_r;
      end
    end

    // Debouncer: flip the level only after a full run of stable mismatching samples
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        db_cnt_r   <= '0;
        deb_r      <= 1'b0;
        deb_prev_r <= 1'b0;
      end else begin
        deb_prev_r <= deb_r;
        if (sync_r == deb_r) begin
          db_cnt_r <= '0;
        end else if (db_cnt_r == DB_W'(DEBOUNCE_LIMIT - 1)) begin
          deb_r    <= ~deb_r;
          db_cnt_r <= '0;
        end else begin
          db_cnt_r <= db_cnt_r + 1'b1;
        end
      end
    end

    // Repeat FSM: step on press, then after the hold delay, then at each period
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        state_r <= ST_IDLE;
        tmr_r   <= '0;
        step_r  <= 1'b0;
      end else begin
        step_r <= 1'b0;
        if (!deb_r) begin
          state_r <= ST_IDLE;
          tmr_r   <= '0;
        end else begin
          case (state_r)
            ST_IDLE: begin
              if (press_s) begin
                state_r <= ST_DELAY;
                tmr_r   <= '0;
                step_r  <= 1'b1;
              end
            end
            ST_DELAY: begin
              if (!solo_s) begin
                tmr_r <= tmr_r;
              end else if (tmr_r == RPT_W'(REPEAT_DELAY - 1)) begin
                state_r <= ST_REPEAT;
                tmr_r   <= '0;
                step_r  <= 1'b1;
              end else begin
                tmr_r <= tmr_r + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (!solo_s) begin
                tmr_r <= tmr_r;
              end else if (tmr_r == RPT_W'(REPEAT_PERIOD - 1)) begin
                tmr_r  <= '0;
                step_r <= 1'b1;
              end else begin
                tmr_r <= tmr_r + 1'b1;
              end
            end
            default: begin
              state_r <= ST_IDLE;
              tmr_r   <= '0;
            end
          endcase
        end
      end
    end
  end

  logic [4*NUM_DIGITS-1:0] count_nxt_s;
  logic                    wrap_nxt_s;

  // Next count: ripple carry or borrow across the digits; opposing steps cancel
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    count_nxt_s = o_Count;
    wrap_nxt_s  = 1'b0;
    carry       = 1'b0;
    dig         = 4'h0;
    if (step_s == 2'b01) begin
      carry = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        dig = o_Count[4*k +: 4];
        if (!carry) begin
          count_nxt_s[4*k +: 4] = dig;
        end else if (dig == DIGIT_MAX) begin
          count_nxt_s[4*k +: 4] = 4'h0;
        end else begin
          count_nxt_s[4*k +: 4] = dig + 4'h1;
          carry = 1'b0;
        end
      end
      wrap_nxt_s = carry;
    end else if (step_s == 2'b10) begin
      carry = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        dig = o_Count[4*k +: 4];
        if (!carry) begin
          count_nxt_s[4*k +: 4] = dig;
        end else if (dig == 4'h0) begin
          count_nxt_s[4*k +: 4] = DIGIT_MAX;
        end else begin
          count_nxt_s[4*k +: 4] = dig - 4'h1;
          carry = 1'b0;
        end
      end
      wrap_nxt_s = carry;
    end else begin
      count_nxt_s = o_Count;
      wrap_nxt_s  = 1'b0;
    end
  end

  // Count and wrap-pulse registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Count <= '0;
      o_Wrap  <= 1'b0;
    end else begin
      o_Count <= count_nxt_s;
      o_Wrap  <= wrap_nxt_s;
    end
  end

  // Segment registers, decoded from the registered count (one-cycle lag)
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        o_Segments[7*k +: 7] <= 7'b1000000;
      end
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        o_Segments[7*k +: 7] <= seg_decode(o_Count[4*k +: 4]);
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_display.sv
// Directed bench for bcd_updown_display.
// It runs a BCD instance and a hex instance side by side.
module tb_bcd_updown_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        up_b, dn_b, up_h, dn_h;
  logic [7:0]  count_b, count_h;
  logic [13:0] seg_b, seg_h;
  logic        wrap_b, wrap_h;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_updown_display #(.NUM_DIGITS(2), .HEX_MODE(0), .DEBOUNCE_LIMIT(4),
                       .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) u_bcd (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch_Up(up_b), .i_Switch_Down(dn_b),
    .o_Count(count_b), .o_Segments(seg_b), .o_Wrap(wrap_b));

  bcd_updown_display #(.NUM_DIGITS(2), .HEX_MODE(1), .DEBOUNCE_LIMIT(4),
                       .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) u_hex (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch_Up(up_h), .i_Switch_Down(dn_h),
    .o_Count(count_h), .o_Segments(seg_h), .o_Wrap(wrap_h));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference glyph table (active-low, A in bit 0)
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [13:0] glyphs(input logic [7:0] v);
    return {glyph(v[7:4]), glyph(v[3:0])};
  endfunction

  // sel: 0 = BCD up, 1 = BCD down, 2 = hex up, 3 = hex down
  function automatic logic [7:0] cnt_of(input int sel);
    return (sel < 2) ? count_b : count_h;
  endfunction
  function automatic logic [13:0] seg_of(input int sel);
    return (sel < 2) ? seg_b : seg_h;
  endfunction
  function automatic logic wrap_of(input int sel);
    return (sel < 2) ? wrap_b : wrap_h;
  endfunction

  task automatic set_btn(input int sel, input logic v);
    case (sel)
      0: up_b = v;
      1: dn_b = v;
      2: up_h = v;
      default: dn_h = v;
    endcase
  endtask

  // Press one button until the count moves, check value, wrap, segment lag, then release
  task automatic do_step(input int sel, input logic [7:0] exp_cnt, input logic exp_wrap,
                         input string tag);
    logic [7:0] start;
    bit seen;
    seen  = 1'b0;
    start = cnt_of(sel);
    set_btn(sel, 1'b1);
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (cnt_of(sel) !== start) seen = 1'b1;
    end
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_cnt"}, 32'(cnt_of(sel)), 32'(exp_cnt));
    check_eq({tag, "_wrap"}, 32'(wrap_of(sel)), 32'(exp_wrap));
    check_eq({tag, "_seglag"}, 32'(seg_of(sel)), 32'(glyphs(start)));
    @(negedge clk);
    check_eq({tag, "_wrap1"}, 32'(wrap_of(sel)), 32'd0);
    check_eq({tag, "_seg"}, 32'(seg_of(sel)), 32'(glyphs(exp_cnt)));
    set_btn(sel, 1'b0);
    repeat (14) @(negedge clk);
    check_eq({tag, "_hold"}, 32'(cnt_of(sel)), 32'(exp_cnt));
  endtask

  int t_chg[8];
  int n_chg;
  logic [7:0] prev;
  logic any_wrap;

  initial begin
    rst_n = 1'b0;
    up_b = 1'b0; dn_b = 1'b0; up_h = 1'b0; dn_h = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_cnt", 32'(count_b), 32'h00);
    check_eq("rst_seg", 32'(seg_b), 32'h2040);
    check_eq("rst_wrap", 32'(wrap_b), 32'd0);
    check_eq("rst_seg_hex", 32'(seg_h), 32'h2040);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Glitch of 3 cycles must not change the debounced level
    up_b = 1'b1;
    repeat (3) @(negedge clk);
    up_b = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("glitch", 32'(count_b), 32'h00);

    do_step(0, 8'h01, 1'b0, "up1");
    check_eq("seg_01", 32'(seg_b), 32'h2079);
    for (int i = 2; i <= 9; i++) do_step(0, 8'(i), 1'b0, "upn");
    do_step(0, 8'h10, 1'b0, "carry");

    // Asynchronous reset in mid-cycle clears the outputs at once
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_cnt", 32'(count_b), 32'h00);
    check_eq("arst_seg", 32'(seg_b), 32'h2040);
    check_eq("arst_wrap", 32'(wrap_b), 32'd0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_step(1, 8'h99, 1'b1, "dn_wrap");
    do_step(0, 8'h00, 1'b1, "up_wrap");

    // Auto-repeat: hold up about 38 cycles and log the cycles where the count changes
    n_chg = 0;
    prev  = count_b;
    up_b  = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (i == 37) up_b = 1'b0;
      if (count_b !== prev) begin
        if (n_chg < 8) t_chg[n_chg] = i;
        n_chg++;
        prev = count_b;
      end
    end
    check_eq("rpt_n", 32'(n_chg), 32'd5);
    check_eq("rpt_d1", 32'(t_chg[1] - t_chg[0]), 32'd20);
    check_eq("rpt_d2", 32'(t_chg[2] - t_chg[1]), 32'd5);
    check_eq("rpt_d3", 32'(t_chg[3] - t_chg[2]), 32'd5);
    check_eq("rpt_d4", 32'(t_chg[4] - t_chg[3]), 32'd5);
    check_eq("rpt_cnt", 32'(count_b), 32'h05);

    // Simultaneous press: steps cancel, no wrap
    any_wrap = 1'b0;
    up_b = 1'b1; dn_b = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      any_wrap |= wrap_b;
    end
    up_b = 1'b0; dn_b = 1'b0;
    repeat (14) @(negedge clk);
    check_eq("both_cnt", 32'(count_b), 32'h05);
    check_eq("both_wrap", 32'(any_wrap), 32'd0);

    // Up held, then down joins: one step each, no repeats while both held
    up_b = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("hold_up", 32'(count_b), 32'h06);
    dn_b = 1'b1;
    repeat (80) @(negedge clk);
    check_eq("hold_both", 32'(count_b), 32'h05);
    up_b = 1'b0; dn_b = 1'b0;
    repeat (14) @(negedge clk);
    check_eq("hold_rel", 32'(count_b), 32'h05);
    do_step(1, 8'h04, 1'b0, "dn_fresh");

    // Hex instance
    do_step(3, 8'hFF, 1'b1, "hx_dn_wrap");
    do_step(2, 8'h00, 1'b1, "hx_up_wrap");
    for (int i = 1; i <= 10; i++) do_step(2, 8'(i), 1'b0, "hx_up");
    check_eq("hx_glyph_a", 32'(seg_h[6:0]), 32'(7'b0001000));
    for (int i = 11; i <= 15; i++) do_step(2, 8'(i), 1'b0, "hx_up");
    do_step(2, 8'h10, 1'b0, "hx_carry");
    check_eq("hx_seg0", 32'(seg_h[6:0]), 32'(7'b1000000));
    check_eq("hx_seg1", 32'(seg_h[13:7]), 32'(7'b1111001));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
